// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants used by the register file and its neighbours.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int NREG   = 8;

   localparam logic [DATA_W-1:0] REG_RESET = 16'h0000;

endpackage : cpu_pkg

// File: rtl/decoder_3to8.sv
// 3-bit binary index to 8-bit one-hot decoder.
module decoder_3to8 (
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   // one-hot expansion of the index
   always_comb begin
      onehot = 8'h00;
      case (sel)
         3'd0:    onehot = 8'b0000_0001;
         3'd1:    onehot = 8'b0000_0010;
         3'd2:    onehot = 8'b0000_0100;
         3'd3:    onehot = 8'b0000_1000;
         3'd4:    onehot = 8'b0001_0000;
         3'd5:    onehot = 8'b0010_0000;
         3'd6:    onehot = 8'b0100_0000;
         3'd7:    onehot = 8'b1000_0000;
         default: onehot = 8'h00;
      endcase
   end

endmodule : decoder_3to8

// File: rtl/regfile_8x16_sb.sv
// 8 x 16 register file: two bypassed combinational read ports, one write port,
// and a per-register pending scoreboard that stalls issue on RAW hazards.
module regfile_8x16_sb #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter bit BYPASS = 1'b1
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iWe,
   input  logic [2:0]        iWAddr,
   input  logic [DATA_W-1:0] iWData,
   input  logic [2:0]        iRAddrA,
   input  logic [2:0]        iRAddrB,
   input  logic              iRdEnA,
   input  logic              iRdEnB,
   input  logic              iIssue,
   input  logic [2:0]        iIssueAddr,
   output logic [DATA_W-1:0] oRDataA,
   output logic [DATA_W-1:0] oRDataB,
   output logic              oStall,
   output logic [NREG-1:0]   oPending
);

   import cpu_pkg::*;

   logic [DATA_W-1:0] rf_r [0:NREG-1];
   logic [NREG-1:0]   pending_r;

   logic [7:0]        dec_s;
   logic [NREG-1:0]   wen_s;
   logic [NREG-1:0]   set_s;
   logic              fwd_a_s;
   logic              fwd_b_s;
   logic              hit_a_s;
   logic              hit_b_s;

   decoder_3to8 u_wdec (
      .sel    (iWAddr),
      .onehot (dec_s)
   );

   assign wen_s = dec_s & {NREG{iWe}};

   // forwarding conditions per read port
   always_comb begin
      fwd_a_s = BYPASS && iWe && (iWAddr == iRAddrA);
      fwd_b_s = BYPASS && iWe && (iWAddr == iRAddrB);
   end

   // read ports with write-through
   always_comb begin
      oRDataA = rf_r[iRAddrA];
      oRDataB = rf_r[iRAddrB];
      if (fwd_a_s) begin
         oRDataA = iWData;
      end else begin
         oRDataA = rf_r[iRAddrA];
      end
      if (fwd_b_s) begin
         oRDataB = iWData;
      end else begin
         oRDataB = rf_r[iRAddrB];
      end
   end

   // hazard detection; a forwarded operand is already satisfied
   always_comb begin
      hit_a_s = iRdEnA && pending_r[iRAddrA] && !fwd_a_s;
      hit_b_s = iRdEnB && pending_r[iRAddrB] && !fwd_b_s;
      oStall  = hit_a_s || hit_b_s;
   end

   // scoreboard set vector; a stalled instruction does not issue
   always_comb begin
      set_s = '0;
      if (iIssue && !oStall) begin
         set_s[iIssueAddr] = 1'b1;
      end else begin
         set_s = '0;
      end
   end

   // register storage and scoreboard; set beats clear since the newer producer owns the register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_r[i] <= REG_RESET;
         end
         pending_r <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wen_s[i]) begin
               rf_r[i] <= iWData;
            end
            if (set_s[i]) begin
               pending_r[i] <= 1'b1;
            end else if (wen_s[i]) begin
               pending_r[i] <= 1'b0;
            end
         end
      end
   end

   assign oPending = pending_r;

endmodule : regfile_8x16_sb

// File: tb/tb_regfile_8x16_sb.sv
// Scoreboard bench for regfile_8x16_sb: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_regfile_8x16_sb;

   typedef struct {
      string       name;
      logic [15:0] rda;
      logic [15:0] rdb;
      logic        stall;
      logic [7:0]  pend;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, we, rd_en_a, rd_en_b, issue;
   logic [2:0]  waddr, raddr_a, raddr_b, issue_addr;
   logic [15:0] wdata, rdata_a, rdata_b;
   logic        stall;
   logic [7:0]  pending;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   // reference state: plain arrays
   logic [15:0] m_rf [8];
   bit          m_pend [8];

   always #5 clk = ~clk;

   regfile_8x16_sb #(.DATA_W(16), .NREG(8), .BYPASS(1'b1)) dut (
      .iClk(clk), .iRst(rst), .iWe(we), .iWAddr(waddr), .iWData(wdata),
      .iRAddrA(raddr_a), .iRAddrB(raddr_b), .iRdEnA(rd_en_a), .iRdEnB(rd_en_b),
      .iIssue(issue), .iIssueAddr(issue_addr),
      .oRDataA(rdata_a), .oRDataB(rdata_b), .oStall(stall), .oPending(pending)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] a);
      if (we && waddr == a) return wdata;
      return m_rf[a];
   endfunction

   function automatic bit m_hit(input bit en, input logic [2:0] a);
      return en && m_pend[a] && !(we && waddr == a);
   endfunction

   function automatic logic [7:0] m_pend_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // drive inputs and queue the expected combinational response
   task automatic set_in(input string name, input bit r, input bit w, input int wa,
                         input logic [15:0] wd, input int ra, input int rb,
                         input bit ea, input bit eb, input bit iss, input int ia);
      exp_t e;
      rst = r; we = w; waddr = 3'(wa); wdata = wd;
      raddr_a = 3'(ra); raddr_b = 3'(rb); rd_en_a = ea; rd_en_b = eb;
      issue = iss; issue_addr = 3'(ia);
      e.name  = name;
      e.rda   = m_read(raddr_a);
      e.rdb   = m_read(raddr_b);
      e.stall = m_hit(rd_en_a, raddr_a) || m_hit(rd_en_b, raddr_b);
      e.pend  = m_pend_vec();
      exp_q.push_back(e);
   endtask

   // advance the model by one edge, then the DUT
   task automatic tick();
      bit st;
      st = m_hit(rd_en_a, raddr_a) || m_hit(rd_en_b, raddr_b);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_rf[i] = 16'h0000;
            m_pend[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (issue && !st && issue_addr == 3'(i)) m_pend[i] = 1'b1;
            else if (we && waddr == 3'(i)) m_pend[i] = 1'b0;
            if (we && waddr == 3'(i)) m_rf[i] = wdata;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // monitor: compare each queued expectation against the live outputs
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, ".rdata_a"}, rdata_a, e.rda);
         check({e.name, ".rdata_b"}, rdata_b, e.rdb);
         check({e.name, ".stall"}, {15'h0000, stall}, {15'h0000, e.stall});
         check({e.name, ".pending"}, {8'h00, pending}, {8'h00, e.pend});
      end
   end

   initial begin
      int guard;
      rst = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
      raddr_a = 3'd0; raddr_b = 3'd0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      issue = 1'b0; issue_addr = 3'd0;
      for (int i = 0; i < 8; i++) begin
         m_rf[i] = 16'h0000;
         m_pend[i] = 1'b0;
      end
      // T1: two reset edges, then sweep every address on both ports
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < 8; a++) begin
         set_in("t1_reset", 1'b0, 1'b0, 0, 16'h0000, a, 7 - a, 1'b1, 1'b1, 1'b0, 0);
         #1;
         check("t1_const_a", rdata_a, 16'h0000);
         check("t1_const_stall", {15'h0000, stall}, 16'h0000);
         tick();
      end
      // T2
      set_in("t2_write", 1'b0, 1'b1, 3, 16'hBEEF, 0, 1, 1'b0, 1'b0, 1'b0, 0);
      tick();
      set_in("t2_read", 1'b0, 1'b0, 0, 16'h0000, 3, 4, 1'b1, 1'b1, 1'b0, 0);
      #1;
      check("t2_const_r3", rdata_a, 16'hBEEF);
      check("t2_const_r4", rdata_b, 16'h0000);
      tick();
      // T3
      set_in("t3_bypass", 1'b0, 1'b1, 5, 16'h1234, 0, 5, 1'b0, 1'b1, 1'b0, 0);
      #1;
      check("t3_const_byp", rdata_b, 16'h1234);
      tick();
      // T4: issue R2, then hold a dependent read; a stalled issue must not set R3
      set_in("t4_issue", 1'b0, 1'b0, 0, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1, 2);
      tick();
      set_in("t4_hazard", 1'b0, 1'b0, 0, 16'h0000, 2, 0, 1'b1, 1'b0, 1'b1, 3);
      #1;
      check("t4_const_pend", {8'h00, pending}, 16'h0004);
      check("t4_const_stall", {15'h0000, stall}, 16'h0001);
      tick();
      set_in("t4_wb", 1'b0, 1'b1, 2, 16'h0007, 2, 0, 1'b1, 1'b0, 1'b0, 0);
      #1;
      check("t4_const_wb_stall", {15'h0000, stall}, 16'h0000);
      check("t4_const_wb_data", rdata_a, 16'h0007);
      tick();
      set_in("t4_after", 1'b0, 1'b0, 0, 16'h0000, 2, 3, 1'b1, 1'b1, 1'b0, 0);
      #1;
      check("t4_const_clear", {8'h00, pending}, 16'h0000);
      tick();
      // T5: set and clear of R6 in the same cycle
      set_in("t5_race", 1'b0, 1'b1, 6, 16'h5A5A, 0, 0, 1'b0, 1'b0, 1'b1, 6);
      tick();
      set_in("t5_check", 1'b0, 1'b0, 0, 16'h0000, 6, 0, 1'b0, 1'b0, 1'b0, 0);
      #1;
      check("t5_const_data", rdata_a, 16'h5A5A);
      check("t5_const_pend", {8'h00, pending}, 16'h0040);
      tick();
      // T6: in-flight state, then reset with a concurrent write and issue
      set_in("t6_iss1", 1'b0, 1'b0, 0, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1, 1);
      tick();
      set_in("t6_iss4", 1'b0, 1'b0, 0, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1, 4);
      tick();
      set_in("t6_w7", 1'b0, 1'b1, 7, 16'hFFFF, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      tick();
      set_in("t6_rst", 1'b1, 1'b1, 0, 16'hAAAA, 7, 1, 1'b1, 1'b1, 1'b1, 5);
      tick();
      set_in("t6_post", 1'b0, 1'b0, 0, 16'h0000, 7, 0, 1'b1, 1'b1, 1'b0, 0);
      #1;
      check("t6_const_pend", {8'h00, pending}, 16'h0000);
      check("t6_const_r7", rdata_a, 16'h0000);
      check("t6_const_r0", rdata_b, 16'h0000);
      check("t6_const_stall", {15'h0000, stall}, 16'h0000);
      tick();
      // random traffic
      for (int n = 0; n < 400; n++) begin
         set_in("rand", ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), 16'($urandom), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                $urandom_range(0, 7));
         tick();
      end
      rst = 1'b0; we = 1'b0; issue = 1'b0;
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      check("drain", 16'(exp_q.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_8x16_sb
